// File: rtl/modadd_ctrl_pkg.sv
// Shared definitions for the modular add/sub sequencer: default operand width and FSM states.
// Build option MODADD_CONST_TIME_EN: sub always runs the D+M pass so latency is data-independent.
package modadd_ctrl_pkg;

  localparam int unsigned N_DEFAULT = 1027;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    P1_GO   = 3'd1,
    P1_WAIT = 3'd2,
    P2_GO   = 3'd3,
    P2_WAIT = 3'd4,
    FIN     = 3'd5
  } state_e;

endpackage

// File: rtl/modadd_ctrl_if.sv
// Request/response bus between the modular add/sub sequencer (master) and the shared mpadder (slave).
interface modadd_ctrl_if
  import modadd_ctrl_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT
);

  logic         add_start;
  logic         add_subtract;
  logic [N-1:0] add_in_a;
  logic [N-1:0] add_in_b;
  logic [N:0]   add_result;
  logic         add_done;

  modport master (
    output add_start,
    output add_subtract,
    output add_in_a,
    output add_in_b,
    input  add_result,
    input  add_done
  );

  modport slave (
    input  add_start,
    input  add_subtract,
    input  add_in_a,
    input  add_in_b,
    output add_result,
    output add_done
  );

endinterface

// File: rtl/modadd_ctrl.sv
// Sequences a shared mpadder through two passes to produce (A +/- B) mod M.
// Build option MODADD_CONST_TIME_EN forces the second pass for sub (data-independent latency).
module modadd_ctrl
  import modadd_ctrl_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  input  logic          subtract,
  input  logic [N-1:0]  in_a,
  input  logic [N-1:0]  in_b,
  input  logic [N-1:0]  in_m,
  output logic [N-1:0]  result,
  output logic          busy,
  output logic          done,
  modadd_ctrl_if.master add_if
);

`ifdef MODADD_CONST_TIME_EN
  localparam bit SKIP_PASS2 = 1'b0;
`else
  localparam bit SKIP_PASS2 = 1'b1;
`endif

  state_e       state_q, state_d;
  logic [N-1:0] m_q, m_d;
  logic         sub_q, sub_d;
  logic [N-1:0] s1_q, s1_d;
  logic         f1_q, f1_d;
  logic [N-1:0] result_q, result_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         add_start_q, add_start_d;
  logic         add_subtract_q, add_subtract_d;
  logic [N-1:0] add_in_a_q, add_in_a_d;
  logic [N-1:0] add_in_b_q, add_in_b_d;

  logic [N-1:0] add_sum;
  logic         add_flag;

  assign add_sum  = add_if.add_result[N-1:0];
  assign add_flag = add_if.add_result[N];

  // Next-state and registered-output logic; operands hold by default until the next issue.
  always_comb begin
    state_d        = state_q;
    m_d            = m_q;
    sub_d          = sub_q;
    s1_d           = s1_q;
    f1_d           = f1_q;
    result_d       = result_q;
    busy_d         = busy_q;
    done_d         = 1'b0;
    add_start_d    = 1'b0;
    add_subtract_d = add_subtract_q;
    add_in_a_d     = add_in_a_q;
    add_in_b_d     = add_in_b_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d        = P1_GO;
          m_d            = in_m;
          sub_d          = subtract;
          busy_d         = 1'b1;
          add_start_d    = 1'b1;
          add_subtract_d = subtract;
          add_in_a_d     = in_a;
          add_in_b_d     = in_b;
        end
      end

      P1_GO: state_d = P1_WAIT;

      P1_WAIT: begin
        if (add_if.add_done) begin
          s1_d = add_sum;
          f1_d = add_flag;
          // A sub without borrow is already reduced; skip the correction pass.
          if (sub_q && !add_flag && SKIP_PASS2) begin
            result_d = add_sum;
            done_d   = 1'b1;
            busy_d   = 1'b0;
            state_d  = FIN;
          end else begin
            state_d        = P2_GO;
            add_start_d    = 1'b1;
            add_subtract_d = ~sub_q;
            add_in_a_d     = add_sum;
            add_in_b_d     = m_q;
          end
        end
      end

      P2_GO: state_d = P2_WAIT;

      P2_WAIT: begin
        if (add_if.add_done) begin
          // add: borrow on S1-M means S1 < M. sub: D+M only applies when pass 1 borrowed.
          if (sub_q) begin
            result_d = f1_q ? add_sum : s1_q;
          end else begin
            result_d = add_flag ? s1_q : add_sum;
          end
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = FIN;
        end
      end

      FIN: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q        <= IDLE;
      m_q            <= '0;
      sub_q          <= 1'b0;
      s1_q           <= '0;
      f1_q           <= 1'b0;
      result_q       <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      add_start_q    <= 1'b0;
      add_subtract_q <= 1'b0;
      add_in_a_q     <= '0;
      add_in_b_q     <= '0;
    end else begin
      state_q        <= state_d;
      m_q            <= m_d;
      sub_q          <= sub_d;
      s1_q           <= s1_d;
      f1_q           <= f1_d;
      result_q       <= result_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      add_start_q    <= add_start_d;
      add_subtract_q <= add_subtract_d;
      add_in_a_q     <= add_in_a_d;
      add_in_b_q     <= add_in_b_d;
    end
  end

  assign result              = result_q;
  assign busy                = busy_q;
  assign done                = done_q;
  assign add_if.add_start    = add_start_q;
  assign add_if.add_subtract = add_subtract_q;
  assign add_if.add_in_a     = add_in_a_q;
  assign add_if.add_in_b     = add_in_b_q;

endmodule

// File: tb/tb_modadd_ctrl.sv
// Directed bench for modadd_ctrl with a 2-cycle mpadder model behind the add_* bus.
module tb_modadd_ctrl;
  import modadd_ctrl_pkg::*;

  localparam int unsigned N = N_DEFAULT;
`ifdef MODADD_CONST_TIME_EN
  localparam int SUB_LAT = 7;
`else
  localparam int SUB_LAT = 4;
`endif

  logic         clk = 1'b0;
  logic         resetn;
  logic         start;
  logic         subtract;
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic [N-1:0] in_m;
  logic [N-1:0] result;
  logic         busy;
  logic         done;

  int passed = 0;
  int total  = 0;
  int cyc;

  always #5 clk = ~clk;

  modadd_ctrl_if #(.N(N)) add_if ();

  modadd_ctrl #(.N(N)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .start    (start),
    .subtract (subtract),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_m     (in_m),
    .result   (result),
    .busy     (busy),
    .done     (done),
    .add_if   (add_if)
  );

  // mpadder model: start seen in cycle c, done/result in cycle c+2; not tied to resetn.
  logic       st1    = 1'b0;
  logic       pdone  = 1'b0;
  logic [N:0] r1     = '0;
  logic [N:0] pres   = '0;

  always @(posedge clk) begin
    st1   <= add_if.add_start;
    pdone <= st1;
    pres  <= r1;
    if (add_if.add_start) begin
      if (add_if.add_subtract) r1 <= (N+1)'(add_if.add_in_a) - (N+1)'(add_if.add_in_b);
      else                     r1 <= (N+1)'(add_if.add_in_a) + (N+1)'(add_if.add_in_b);
    end
  end

  assign add_if.add_result = pres;
  assign add_if.add_done   = pdone;

  task automatic check(input string tag, input logic [N:0] obs, input logic [N:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done();
    while (done !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic run_op(input bit sub, input int unsigned a, input int unsigned b,
                        input int unsigned m, input int unsigned exp_r, input int lat,
                        input string tag);
    @(negedge clk);
    start = 1'b1; subtract = sub;
    in_a = N'(a); in_b = N'(b); in_m = N'(m);
    @(negedge clk);
    start = 1'b0; cyc = 1;
    check({tag, "_busy"},      (N+1)'(busy), (N+1)'(1));
    check({tag, "_astart"},    (N+1)'(add_if.add_start), (N+1)'(1));
    check({tag, "_ain_a"},     (N+1)'(add_if.add_in_a), (N+1)'(a));
    check({tag, "_asub"},      (N+1)'(add_if.add_subtract), (N+1)'(sub));
    @(negedge clk);
    cyc = 2;
    check({tag, "_astart_pulse"}, (N+1)'(add_if.add_start), (N+1)'(0));
    wait_done();
    check({tag, "_latency"},   (N+1)'(cyc), (N+1)'(lat));
    check({tag, "_result"},    (N+1)'(result), (N+1)'(exp_r));
    @(negedge clk);
    check({tag, "_done_pulse"}, (N+1)'(done), (N+1)'(0));
    check({tag, "_busy_idle"},  (N+1)'(busy), (N+1)'(0));
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; subtract = 1'b0;
    in_a = '0; in_b = '0; in_m = '0;
    repeat (3) @(negedge clk);
    check("rst_result", (N+1)'(result), '0);
    check("rst_busy",   (N+1)'(busy), '0);
    check("rst_done",   (N+1)'(done), '0);
    check("rst_astart", (N+1)'(add_if.add_start), '0);
    check("rst_asub",   (N+1)'(add_if.add_subtract), '0);
    check("rst_ain_a",  (N+1)'(add_if.add_in_a), '0);
    check("rst_ain_b",  (N+1)'(add_if.add_in_b), '0);
    resetn = 1'b1;
    @(negedge clk);

    run_op(1'b0, 7, 9, 13, 3, 7, "add_7_9");
    run_op(1'b0, 5, 6, 13, 11, 7, "add_5_6");
    run_op(1'b1, 3, 8, 13, 8, 7, "sub_3_8");
    run_op(1'b1, 8, 3, 13, 5, SUB_LAT, "sub_8_3");
    run_op(1'b0, 6, 7, 13, 0, 7, "add_eq_m");
    run_op(1'b1, 9, 9, 13, 0, SUB_LAT, "sub_eq");

    // start pulsed again during P1_WAIT must be dropped
    @(negedge clk);
    start = 1'b1; subtract = 1'b0; in_a = N'(7); in_b = N'(9); in_m = N'(13);
    @(negedge clk);
    start = 1'b0; cyc = 1;
    @(negedge clk);
    cyc = 2;
    start = 1'b1; subtract = 1'b1; in_a = N'(1); in_b = N'(2); in_m = N'(5);
    @(negedge clk);
    start = 1'b0; cyc = 3;
    wait_done();
    check("ign_latency", (N+1)'(cyc), (N+1)'(7));
    check("ign_result",  (N+1)'(result), (N+1)'(3));
    @(negedge clk);
    check("ign_no_restart", (N+1)'(busy), '0);
    repeat (6) @(negedge clk);
    check("ign_not_queued", (N+1)'(busy), '0);

    // reset while in P2_WAIT, stale add_done follows
    start = 1'b1; subtract = 1'b0; in_a = N'(7); in_b = N'(9); in_m = N'(13);
    @(negedge clk);
    start = 1'b0; cyc = 1;
    repeat (4) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    check("abort_result", (N+1)'(result), '0);
    check("abort_busy",   (N+1)'(busy), '0);
    check("abort_done",   (N+1)'(done), '0);
    check("abort_astart", (N+1)'(add_if.add_start), '0);
    check("abort_asub",   (N+1)'(add_if.add_subtract), '0);
    check("abort_ain_a",  (N+1)'(add_if.add_in_a), '0);
    check("abort_ain_b",  (N+1)'(add_if.add_in_b), '0);
    check("abort_stale_present", (N+1)'(add_if.add_done), (N+1)'(1));
    resetn = 1'b1;
    @(negedge clk);
    check("stale_done",   (N+1)'(done), '0);
    check("stale_busy",   (N+1)'(busy), '0);
    check("stale_result", (N+1)'(result), '0);
    run_op(1'b0, 12, 12, 13, 11, 7, "add_12_12");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
